// File: rtl/alu_mc_pkg.sv
// Shared opcodes, FSM state encoding and compare result codes for the
// multi-cycle ALU (alu_mc) and its iterative divider.
package alu_mc_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_MUL  = 4'b0010;
  localparam logic [3:0] ALU_DIV  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_NAND = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_XNOR = 4'b1001;
  localparam logic [3:0] ALU_EQ   = 4'b1010;
  localparam logic [3:0] ALU_GT   = 4'b1011;
  localparam logic [3:0] ALU_LT   = 4'b1100;
  localparam logic [3:0] ALU_SHR  = 4'b1101;
  localparam logic [3:0] ALU_SHL  = 4'b1110;
  localparam logic [3:0] ALU_NOP  = 4'b1111;

  localparam int CMP_EQ = 1;
  localparam int CMP_GT = 2;
  localparam int CMP_LT = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/alu_div_iter.sv
// Restoring divider: one quotient bit per cycle for W cycles after start.
// done is high during the last iteration, with the final quotient/remainder.
module alu_div_iter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic          active;
  logic [CW-1:0] cnt;
  logic [W-1:0]  quo;
  logic [W-1:0]  rem;
  logic [W-1:0]  dvs;
  logic [W:0]    trial;
  logic [W:0]    diff;
  logic          fits;

  // The dividend is shifted out of quo MSB-first while quotient bits enter at the LSB.
  assign trial     = {rem, quo[W-1]};
  assign diff      = trial - {1'b0, dvs};
  assign fits      = ~diff[W];
  assign remainder = fits ? diff[W-1:0] : trial[W-1:0];
  assign quotient  = {quo[W-2:0], fits};
  assign done      = active && (cnt == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      quo    <= dividend;
      rem    <= '0;
      dvs    <= divisor;
    end else if (active) begin
      quo    <= quotient;
      rem    <= remainder;
      cnt    <= cnt + CW'(1);
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready on both sides and an iterative divider.
// Define ALU_SIGNED_CMP_EN to make opcodes 1011/1100 signed compares.
//
// Handshake: a transfer happens on a CLK edge where valid and ready are both
// high; a producer holds valid and its payload stable until that edge, and
// ALU_OUT/DIV_ZERO stay stable while OUT_VALID=1 and OUT_READY=0.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int OPER_WIDTH = 8,
  parameter int OUT_WIDTH  = 2 * OPER_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [OPER_WIDTH-1:0] A,
  input  logic [OPER_WIDTH-1:0] B,
  input  logic [3:0]            ALU_FUN,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [OUT_WIDTH-1:0]  ALU_OUT,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  DIV_ZERO,
  output logic                  BUSY
);

  state_t                 state, state_next;
  logic                   accept, div_start, load_single;
  logic                   div_done;
  logic [OPER_WIDTH-1:0]  div_quo, div_rem;
  logic [OUT_WIDTH-1:0]   a_ext, b_ext, single_res;
  logic [OPER_WIDTH-1:0]  logic_res;
  logic                   single_dz, gt, lt;

  assign accept      = IN_VALID & IN_READY;
  assign div_start   = accept && (ALU_FUN == ALU_DIV) && (B != '0);
  assign load_single = accept && !div_start;

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    IN_READY   = 1'b0;
    BUSY       = 1'b0;
    case (state)
      S_IDLE: begin
        IN_READY = !OUT_VALID || OUT_READY;
        if (div_start)                      state_next = S_DIV;
        else if (load_single && !OUT_READY) state_next = S_HOLD;
      end
      S_DIV: begin
        BUSY = 1'b1;
        if (div_done) state_next = S_HOLD;
      end
      S_HOLD: begin
        if (OUT_VALID && OUT_READY) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  alu_div_iter #(.W(OPER_WIDTH)) u_div (
    .clk       (CLK),
    .rst       (RST),
    .start     (div_start),
    .dividend  (A),
    .divisor   (B),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

`ifdef ALU_SIGNED_CMP_EN
  assign gt = $signed(A) > $signed(B);
  assign lt = $signed(A) < $signed(B);
`else
  assign gt = A > B;
  assign lt = A < B;
`endif

  assign a_ext = OUT_WIDTH'(A);
  assign b_ext = OUT_WIDTH'(B);

  // Logic ops are formed at operand width so inversions never reach the upper half.
  always_comb begin
    logic_res = '0;
    case (ALU_FUN)
      ALU_AND:  logic_res = A & B;
      ALU_OR:   logic_res = A | B;
      ALU_NAND: logic_res = ~(A & B);
      ALU_NOR:  logic_res = ~(A | B);
      ALU_XOR:  logic_res = A ^ B;
      ALU_XNOR: logic_res = ~(A ^ B);
      default:  logic_res = '0;
    endcase
  end

  always_comb begin
    single_res = '0;
    single_dz  = 1'b0;
    case (ALU_FUN)
      ALU_ADD: single_res = a_ext + b_ext;
      ALU_SUB: single_res = a_ext - b_ext;
      ALU_MUL: single_res = a_ext * b_ext;
      ALU_DIV: begin
        single_res = {A, {OPER_WIDTH{1'b1}}};
        single_dz  = 1'b1;
      end
      ALU_AND, ALU_OR, ALU_NAND, ALU_NOR, ALU_XOR, ALU_XNOR:
        single_res = {{OPER_WIDTH{1'b0}}, logic_res};
      ALU_EQ:  single_res = (A == B) ? OUT_WIDTH'(CMP_EQ) : '0;
      ALU_GT:  single_res = gt ? OUT_WIDTH'(CMP_GT) : '0;
      ALU_LT:  single_res = lt ? OUT_WIDTH'(CMP_LT) : '0;
      ALU_SHR: single_res = a_ext >> 1;
      ALU_SHL: single_res = a_ext << 1;
      default: single_res = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ALU_OUT   <= '0;
      OUT_VALID <= 1'b0;
      DIV_ZERO  <= 1'b0;
    end else if (load_single) begin
      ALU_OUT   <= single_res;
      DIV_ZERO  <= single_dz;
      OUT_VALID <= 1'b1;
    end else if (div_done) begin
      ALU_OUT   <= {div_rem, div_quo};
      DIV_ZERO  <= 1'b0;
      OUT_VALID <= 1'b1;
    end else if (OUT_VALID && OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (OPER_WIDTH=8): directed timing cases then
// randomized traffic scored against an arithmetic reference model.
module tb_alu_mc;

  localparam int W  = 8;
  localparam int OW = 2 * W;
  localparam int EW = OW + 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic [3:0]    ALU_FUN = '0;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [OW-1:0] ALU_OUT;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b0;
  logic          DIV_ZERO;
  logic          BUSY;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  logic [EW-1:0] exp_q[$];

  alu_mc #(.OPER_WIDTH(W), .OUT_WIDTH(OW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .A         (A),
    .B         (B),
    .ALU_FUN   (ALU_FUN),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .ALU_OUT   (ALU_OUT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .DIV_ZERO  (DIV_ZERO),
    .BUSY      (BUSY)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // reference model: {div_zero, result} from the opcode table
  function automatic logic [EW-1:0] ref_model(input int unsigned a, input int unsigned b,
                                              input int unsigned f);
    int unsigned r;
    int unsigned wm;
    int unsigned om;
    bit dz;
`ifdef ALU_SIGNED_CMP_EN
    int sa;
    int sb;
    sa = (a >= (1 << (W - 1))) ? int'(a) - (1 << W) : int'(a);
    sb = (b >= (1 << (W - 1))) ? int'(b) - (1 << W) : int'(b);
`endif
    r  = 0;
    dz = 1'b0;
    wm = (1 << W) - 1;
    om = (1 << OW) - 1;
    case (f)
      0:  r = a + b;
      1:  r = (a - b) & om;
      2:  r = a * b;
      3:  if (b == 0) begin dz = 1'b1; r = (a << W) | wm; end
          else r = ((a % b) << W) | (a / b);
      4:  r = a & b;
      5:  r = a | b;
      6:  r = ~(a & b) & wm;
      7:  r = ~(a | b) & wm;
      8:  r = a ^ b;
      9:  r = ~(a ^ b) & wm;
      10: r = (a == b) ? 1 : 0;
`ifdef ALU_SIGNED_CMP_EN
      11: r = (sa > sb) ? 2 : 0;
      12: r = (sa < sb) ? 3 : 0;
`else
      11: r = (a > b) ? 2 : 0;
      12: r = (a < b) ? 3 : 0;
`endif
      13: r = a >> 1;
      14: r = a << 1;
      default: r = 0;
    endcase
    return {dz, r[OW-1:0]};
  endfunction

  // scoreboard: compare every output transfer against the oldest expected result
  always @(negedge CLK) begin
    if (mon_en && OUT_VALID && OUT_READY) begin
      if (exp_q.size() == 0) check("unexpected_out", {DIV_ZERO, ALU_OUT}, 32'hDEAD_BEEF);
      else                   check("rand_result", {DIV_ZERO, ALU_OUT}, exp_q.pop_front());
    end
  end

  // one single-cycle operation with OUT_READY high; result checked one cycle after accept
  task automatic run_single(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] f,
                            input logic [OW-1:0] exp_out, input logic exp_dz, input string tag);
    OUT_READY = 1'b1;
    A = a; B = b; ALU_FUN = f; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    @(negedge CLK);
    check(tag, {OUT_VALID, DIV_ZERO, ALU_OUT}, {1'b1, exp_dz, exp_out});
    tick();
  endtask

  // randomized driver: hold request until handshake, random backpressure
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] f);
    bit hs;
    hs = 1'b0;
    A = a; B = b; ALU_FUN = f; IN_VALID = 1'b1;
    for (int i = 0; i < 100 && !hs; i++) begin
      OUT_READY = ($urandom_range(0, 3) != 0);
      @(negedge CLK);
      hs = IN_READY;
      if (hs) exp_q.push_back(ref_model(a, b, f));
      tick();
    end
    IN_VALID = 1'b0;
    if (!hs) check("accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit late;
    logic [W-1:0] ra, rb;
    logic [3:0]   rf;

    RST = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
    @(negedge CLK);
    check("reset_outs", {OUT_VALID, DIV_ZERO, BUSY, IN_READY, ALU_OUT}, {4'b0001, 16'h0000});
    tick();

    // ADD with latency 1 and IN_READY staying high
    OUT_READY = 1'b1;
    A = 8'd200; B = 8'd100; ALU_FUN = 4'b0000; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    @(negedge CLK);
    check("add_out", {OUT_VALID, DIV_ZERO, ALU_OUT}, {2'b10, 16'h012C});
    check("add_in_ready", IN_READY, 1);
    tick();

    // DIV 100/7: 8 busy cycles, result 9 cycles after the handshake cycle
    A = 8'd100; B = 8'd7; ALU_FUN = 4'b0011; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      check($sformatf("div_busy_c%0d", i + 1), {BUSY, IN_READY, OUT_VALID}, 3'b100);
      tick();
    end
    @(negedge CLK);
    check("div_out", {OUT_VALID, DIV_ZERO, BUSY, ALU_OUT}, {3'b100, 16'h020E});
    tick();

    run_single(8'h55, 8'h00, 4'b0011, 16'h55FF, 1'b1, "div_zero");

    // MUL held under backpressure
    OUT_READY = 1'b0;
    A = 8'd255; B = 8'd255; ALU_FUN = 4'b0010; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check($sformatf("mul_hold_c%0d", i), {OUT_VALID, IN_READY, ALU_OUT}, {2'b10, 16'hFE01});
      tick();
    end
    // release together with a new ADD request; it is accepted once the hold ends
    A = 8'd1; B = 8'd1; ALU_FUN = 4'b0000; IN_VALID = 1'b1; OUT_READY = 1'b1;
    @(negedge CLK);
    check("release_in_ready", IN_READY, 0);
    tick();
    @(negedge CLK);
    check("after_release", {OUT_VALID, IN_READY}, 2'b01);
    tick();
    IN_VALID = 1'b0;
    @(negedge CLK);
    check("add_after_hold", {OUT_VALID, ALU_OUT}, {1'b1, 16'h0002});
    tick();

    // reset during the 4th divide cycle
    A = 8'd200; B = 8'd3; ALU_FUN = 4'b0011; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    repeat (3) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    @(negedge CLK);
    check("mid_div_reset", {BUSY, OUT_VALID, IN_READY, ALU_OUT}, {3'b001, 16'h0000});
    late = 1'b0;
    repeat (12) begin
      @(negedge CLK);
      if (OUT_VALID) late = 1'b1;
    end
    check("no_late_result", late, 0);
    tick();

`ifdef ALU_SIGNED_CMP_EN
    run_single(8'hFF, 8'h01, 4'b1100, 16'd3, 1'b0, "cmp_lt");
    run_single(8'hFF, 8'h01, 4'b1011, 16'd0, 1'b0, "cmp_gt");
`else
    run_single(8'hFF, 8'h01, 4'b1100, 16'd0, 1'b0, "cmp_lt");
    run_single(8'hFF, 8'h01, 4'b1011, 16'd2, 1'b0, "cmp_gt");
`endif
    run_single(8'hA5, 8'h3C, 4'b1111, 16'd0, 1'b0, "op_nop");
    run_single(8'h80, 8'h01, 4'b1110, 16'h0100, 1'b0, "shl_carry");
    run_single(8'h10, 8'h20, 4'b0001, 16'hFFF0, 1'b0, "sub_wrap");
    run_single(8'hF0, 8'h0F, 4'b0110, 16'h00FF, 1'b0, "nand_low");
    repeat (2) tick();

    // randomized traffic
    mon_en = 1'b1;
    for (int n = 0; n < 250; n++) begin
      rf = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rf = 4'b0011;
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) rb = ra;
      send(ra, rb, rf);
      if ($urandom_range(0, 4) == 0) begin
        OUT_READY = ($urandom_range(0, 1) != 0);
        tick();
      end
    end
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) begin
      OUT_READY = ($urandom_range(0, 1) != 0);
      tick();
    end
    OUT_READY = 1'b1;
    repeat (3) tick();
    check("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
